// File: rtl/tictactoe_game_engine_if.sv
// Bus between the game engine and its neighbours: click/restart/score-clear
// inputs in, board, turn, screen-select and score outputs back.
interface tictactoe_game_engine_if;
  localparam int unsigned SQUARES = 9;
  localparam int unsigned SCORE_W = 6;

  logic [SQUARES-1:0] clicked_square;
  logic               restart;
  logic               reset_score;
  logic [SQUARES-1:0] x_matrix;
  logic [SQUARES-1:0] o_matrix;
  logic               turn_x;
  logic               turn_o;
  logic               show_start;
  logic               show_playing;
  logic               show_winner_x;
  logic               show_winner_o;
  logic               show_tie;
  logic [SCORE_W-1:0] score_x;
  logic [SCORE_W-1:0] score_o;

  modport master (
    output clicked_square, restart, reset_score,
    input  x_matrix, o_matrix, turn_x, turn_o,
    input  show_start, show_playing, show_winner_x, show_winner_o, show_tie,
    input  score_x, score_o
  );

  modport slave (
    input  clicked_square, restart, reset_score,
    output x_matrix, o_matrix, turn_x, turn_o,
    output show_start, show_playing, show_winner_x, show_winner_o, show_tie,
    output score_x, score_o
  );
endinterface

// File: rtl/tictactoe_game_engine.sv
// TicTacToe rule engine: owns board, turn, screen selection and scores.
// Moves are accepted on click edges, judged one cycle later in CHECK.
module tictactoe_game_engine #(
  parameter int unsigned SCORE_MAX = 63
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  tictactoe_game_engine_if.slave  bus
);
  localparam int unsigned SQUARES = 9;
  localparam int unsigned SCORE_W = 6;
  localparam int unsigned SHOW_W  = 5;

  typedef enum logic [2:0] {
    ST_START,
    ST_PLAY,
    ST_CHECK,
    ST_WIN_X,
    ST_WIN_O,
    ST_TIE
  } state_t;

  // show vector order: {start, playing, winner_x, winner_o, tie}
  localparam logic [SHOW_W-1:0] SHOW_START = SHOW_W'(5'b10000);
  localparam logic [SHOW_W-1:0] SHOW_PLAY  = SHOW_W'(5'b01000);
  localparam logic [SHOW_W-1:0] SHOW_WX    = SHOW_W'(5'b00100);
  localparam logic [SHOW_W-1:0] SHOW_WO    = SHOW_W'(5'b00010);
  localparam logic [SHOW_W-1:0] SHOW_TIE   = SHOW_W'(5'b00001);

  state_t             state_q, state_d;
  logic [SQUARES-1:0] x_q, x_d, o_q, o_d;
  logic               turn_x_q, turn_x_d, turn_o_q;
  logic               starter_x_q, starter_x_d;
  logic [SCORE_W-1:0] score_x_q, score_x_d, score_o_q, score_o_d;
  logic [SHOW_W-1:0]  show_q, show_d;
  logic               click_prev_q, restart_prev_q, post_reset_q;

  logic               click_any_c, click_edge_c, restart_edge_c;
  logic               single_c, empty_c, legal_c;
  logic [SQUARES-1:0] mover_c;

  function automatic logic has_line(input logic [SQUARES-1:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
  endfunction

  // A click held through reset is absorbed by the post-reset cycle.
  assign click_any_c    = |bus.clicked_square;
  assign click_edge_c   = click_any_c & ~click_prev_q & ~post_reset_q;
  assign restart_edge_c = bus.restart & ~restart_prev_q;
  assign single_c       = click_any_c &
                          ((bus.clicked_square & (bus.clicked_square - SQUARES'(1))) == '0);
  assign empty_c        = ((x_q | o_q) & bus.clicked_square) == '0;
  assign legal_c        = click_edge_c & single_c & empty_c;
  assign mover_c        = turn_x_q ? x_q : o_q;

  // Next-state and next-value logic for the whole engine.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    o_d         = o_q;
    turn_x_d    = turn_x_q;
    starter_x_d = starter_x_q;
    score_x_d   = score_x_q;
    score_o_d   = score_o_q;
    show_d      = SHOW_START;

    unique case (state_q)
      ST_START: begin
        x_d         = '0;
        o_d         = '0;
        turn_x_d    = 1'b1;
        starter_x_d = 1'b1;
        if (click_edge_c || restart_edge_c) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (restart_edge_c) begin
          x_d      = '0;
          o_d      = '0;
          turn_x_d = starter_x_q;
        end else if (legal_c) begin
          if (turn_x_q) x_d = x_q | bus.clicked_square;
          else          o_d = o_q | bus.clicked_square;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (has_line(mover_c)) begin
          if (turn_x_q) begin
            state_d   = ST_WIN_X;
            score_x_d = sat_inc(score_x_q);
          end else begin
            state_d   = ST_WIN_O;
            score_o_d = sat_inc(score_o_q);
          end
        end else if ((x_q | o_q) == {SQUARES{1'b1}}) begin
          state_d = ST_TIE;
        end else begin
          turn_x_d = ~turn_x_q;
          state_d  = ST_PLAY;
        end
      end
      ST_WIN_X, ST_WIN_O, ST_TIE: begin
        if (restart_edge_c) begin
          x_d         = '0;
          o_d         = '0;
          starter_x_d = ~starter_x_q;
          turn_x_d    = ~starter_x_q;
          state_d     = ST_PLAY;
        end
      end
      default: state_d = ST_START;
    endcase

    if (bus.reset_score) begin
      score_x_d = '0;
      score_o_d = '0;
    end

    unique case (state_d)
      ST_START:          show_d = SHOW_START;
      ST_PLAY, ST_CHECK: show_d = SHOW_PLAY;
      ST_WIN_X:          show_d = SHOW_WX;
      ST_WIN_O:          show_d = SHOW_WO;
      ST_TIE:            show_d = SHOW_TIE;
      default:           show_d = SHOW_START;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q        <= ST_START;
      x_q            <= '0;
      o_q            <= '0;
      turn_x_q       <= 1'b1;
      turn_o_q       <= 1'b0;
      starter_x_q    <= 1'b1;
      score_x_q      <= '0;
      score_o_q      <= '0;
      show_q         <= SHOW_START;
      click_prev_q   <= 1'b0;
      restart_prev_q <= 1'b0;
      post_reset_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      o_q            <= o_d;
      turn_x_q       <= turn_x_d;
      turn_o_q       <= ~turn_x_d;
      starter_x_q    <= starter_x_d;
      score_x_q      <= score_x_d;
      score_o_q      <= score_o_d;
      show_q         <= show_d;
      click_prev_q   <= click_any_c;
      restart_prev_q <= bus.restart;
      post_reset_q   <= 1'b0;
    end
  end

  assign bus.x_matrix      = x_q;
  assign bus.o_matrix      = o_q;
  assign bus.turn_x        = turn_x_q;
  assign bus.turn_o        = turn_o_q;
  assign bus.show_start    = show_q[4];
  assign bus.show_playing  = show_q[3];
  assign bus.show_winner_x = show_q[2];
  assign bus.show_winner_o = show_q[1];
  assign bus.show_tie      = show_q[0];
  assign bus.score_x       = score_x_q;
  assign bus.score_o       = score_o_q;
endmodule

// File: doc/tictactoe_game_engine.md
# tictactoe_game_engine

Game-rule engine for the TicTacToe design. Consumes the one-hot square-click vector produced by the mouse click-to-square decoder and a restart button. Owns the board (`x_matrix`, `o_matrix`), turn flags, screen-select flags and both 6-bit scores. Feeds the VGA painter and the two-digit score decoders directly.

## Interface
- `SCORE_MAX`, default 63: saturation value of each score counter; must fit in 6 bits.
- `clk_100MHz`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; returns every register to its reset value.
- `clicked_square`  in  9  level vector from the click decoder; bit i = square i (row-major, bit 0 top-left) under a pressed button.
- `restart`  in  1  level restart button; rising edge used.
- `reset_score`  in  1  level; clears both scores while high.
- `x_matrix`, `o_matrix`  out  9  board occupancy; bit i set = X/O on square i.
- `turn_x`, `turn_o`  out  1  side to move; always complementary.
- `show_start`, `show_playing`, `show_winner_x`, `show_winner_o`, `show_tie`  out  1  screen select; exactly one high at all times.
- `score_x`, `score_o`  out  6  round wins, saturating at SCORE_MAX.

## Operation
- Edge detection:
  - `click_prev` <= |clicked_square each cycle.
  - `click_edge` = |clicked_square & ~click_prev.
  - `restart_prev`/`restart_edge` are formed the same way.
- States: START, PLAY, CHECK, WIN_X, WIN_O, TIE. One-hot screen flags decode the state:
  - START -> show_start.
  - PLAY and CHECK -> show_playing.
  - WIN_X -> show_winner_x; WIN_O -> show_winner_o; TIE -> show_tie.
- START:
  - click_edge or restart_edge -> PLAY.
  - Board cleared, X to move, `starter` = X.
- PLAY, move acceptance:
  - A move is legal when click_edge is high, clicked_square has exactly one bit set, and that square is empty in (x_matrix | o_matrix).
  - Legal move: OR the bit into the mover's matrix, then -> CHECK.
  - Illegal edges (multi-bit or occupied square) are ignored; state and turn are unchanged.
  - restart_edge in PLAY clears the board, sets the turn to `starter`, keeps scores, and stays in PLAY. restart_edge has priority over a same-cycle click.
- CHECK (exactly one cycle), evaluating the mover's matrix against the 8 lines: rows {0,1,2}{3,4,5}{6,7,8}, columns {0,3,6}{1,4,7}{2,5,8}, diagonals {0,4,8}{2,4,6}:
  - Mover has any full line -> WIN_X or WIN_O; mover's score increments by 1, saturating at SCORE_MAX.
  - Else, if (x|o) == 9'h1FF -> TIE.
  - Else toggle turn -> PLAY.
  - A win on the ninth move is a win, not a tie.
  - restart and clicks are ignored in CHECK.
- WIN_X / WIN_O / TIE:
  - The board is held for display; clicks are ignored.
  - restart_edge -> PLAY, board cleared, `starter` toggled, turn = new starter. Rounds alternate first player.
- reset_score is honoured in every state. If it is high in the same cycle as an increment, the score goes to 0 (clear wins).
- reset values:
  - State START; x_matrix = o_matrix = 0.
  - turn_x = 1, turn_o = 0; starter = X.
  - show_start = 1, all other show_* = 0.
  - score_x = score_o = 0.
  - click_prev = restart_prev = 0.
  - Reset mid-round discards the board and scores.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Legal click edge sampled at rising edge N: the matrix bit is visible after edge N, CHECK is active in cycle N..N+1, and the result is visible after edge N+1:
  - screen flags, score, or toggled turn.
- Minimum spacing between accepted moves is 2 cycles. A click held for many cycles produces exactly one edge.
- A click already held when reset deasserts does not generate an edge until it is released and pressed again. Implement this by setting click_prev to |clicked_square on the first cycle after reset.
- restart_edge in a result state: board cleared and show_playing high after the sampling edge.
- Score saturation: at SCORE_MAX a further win leaves the score unchanged while the win screen is still entered.

## Test plan
- Reset, then a click on square 4 -> START→PLAY; a second click on 4 places X on bit 4 (x_matrix = 9'h010); after CHECK, turn_o = 1.
- X plays 0, 1, 2 with O on 3, 4 interleaved -> show_winner_x = 1 two cycles after the last edge, score_x = 1, x_matrix = 9'h007, o_matrix = 9'h018.
- Click an occupied square, then a 2-bit clicked_square, then hold one click for 100 cycles -> exactly one move accepted; board otherwise unchanged.
- Full board with no line, sequence X:0,2,3,7,8 / O:1,4,5,6 -> show_tie after the 9th move, scores unchanged. Then restart_edge -> board 0, turn_o = 1 (O starts round 2).
- Preload score_x = 63 via 63 X wins -> 64th win shows winner X, score_x stays 63. Then reset_score with a same-cycle win -> score 0.
- Assert reset in the middle of a round (board nonzero, score_o = 2) -> on the next cycle all outputs equal their reset values; show_start = 1.
